// File: rtl/gf2m_pkg.sv
// Shared definitions for the digit-serial GF(2^M) multiplier:
// default AES reduction polynomial, FSM state type and the xtime helper
// (multiply by x modulo P) used by both the datapath and the reference model.
package gf2m_pkg;

  localparam int unsigned GF2M_MAX_M = 32;
  localparam logic [7:0]  AES_POLY   = 8'h1B;

  typedef logic [GF2M_MAX_M-1:0] gf2m_word_t;
  typedef logic [GF2M_MAX_M:0]   gf2m_wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf2m_state_t;

  // acc*x mod P for a field of degree m (m <= GF2M_MAX_M); x^m is implicit in poly.
  function automatic gf2m_word_t gf2m_xtime(input gf2m_word_t  acc,
                                            input gf2m_word_t  poly,
                                            input int unsigned m = 8);
    gf2m_wide_t w_one_hot;
    gf2m_word_t w_mask;
    gf2m_word_t w_msb;
    w_one_hot = gf2m_wide_t'(1) << m;
    w_mask    = gf2m_word_t'(w_one_hot - gf2m_wide_t'(1));
    w_msb     = gf2m_word_t'(w_one_hot >> 1);
    return ((acc << 1) & w_mask) ^ (((acc & w_msb) != '0) ? (poly & w_mask) : '0);
  endfunction

endpackage

// File: rtl/gf2m_mult_serial_if.sv
// Operand/product handshake bundle for gf2m_mult_serial.
//   in_valid/in_ready/a/b   : operand pair, accepted when in_valid & in_ready
//   out_valid/out_ready/c   : product, consumed when out_valid & out_ready
// master = producer of operands / consumer of products; slave = multiplier.
interface gf2m_mult_serial_if #(
  parameter int unsigned M = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );

endinterface

// File: rtl/gf2m_digit_step.sv
// One cycle of the MSB-first multiplier datapath: applies DIGIT Horner steps
//   acc <- (acc*x mod P) ^ (b_i ? areg : 0)
// for the top DIGIT multiplier bits, most significant first.
// Ports:
//   i_acc    : current accumulator
//   i_areg   : latched multiplicand
//   i_bdig   : next DIGIT multiplier bits (MSB = first bit to consume)
//   o_acc_c  : accumulator after the DIGIT steps (combinational)
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int unsigned    M     = 8,
  parameter logic [M-1:0]   POLY  = M'(AES_POLY),
  parameter int unsigned    DIGIT = 1
) (
  input  logic [M-1:0]     i_acc,
  input  logic [M-1:0]     i_areg,
  input  logic [DIGIT-1:0] i_bdig,
  output logic [M-1:0]     o_acc_c
);

  logic [M-1:0]     w_acc;
  logic [DIGIT-1:0] w_bits;

  // Unrolled chain; w_bits is shifted so its MSB is always the current bit.
  always_comb begin
    w_acc  = i_acc;
    w_bits = i_bdig;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      w_acc  = M'(gf2m_xtime(gf2m_word_t'(w_acc), gf2m_word_t'(POLY), M))
             ^ (w_bits[DIGIT-1] ? i_areg : '0);
      w_bits = w_bits << 1;
    end
    o_acc_c = w_acc;
  end

endmodule

// File: rtl/gf2m_mult_serial.sv
// Digit-serial GF(2^M) multiplier, C = A*B mod P(x), M/DIGIT cycles per product.
// Constant-time: every operand pair takes exactly N = M/DIGIT BUSY cycles.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus.slave : in_valid/in_ready/a/b operand handshake,
//               out_valid/out_ready/c product handshake (c, out_valid registered;
//               in_ready combinational from state and out_ready)
module gf2m_mult_serial
  import gf2m_pkg::*;
#(
  parameter int unsigned  M     = 8,
  parameter logic [M-1:0] POLY  = M'(AES_POLY),
  parameter int unsigned  DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gf2m_mult_serial_if.slave    bus
);

  localparam int unsigned N  = M / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time parameter sanity.
  if (DIGIT == 0) begin : g_bad_digit_zero
    $error("gf2m_mult_serial: DIGIT must be non-zero");
  end else if ((M % DIGIT) != 0) begin : g_bad_digit_div
    $error("gf2m_mult_serial: DIGIT must divide M");
  end
  if ((M == 0) || (M > GF2M_MAX_M)) begin : g_bad_m
    $error("gf2m_mult_serial: M out of supported range");
  end

  gf2m_state_t   r_state;
  gf2m_state_t   w_state_nxt;
  logic [M-1:0]  r_areg;
  logic [M-1:0]  r_breg;
  logic [M-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_c;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic          w_release;
  logic [M-1:0]  w_acc_nxt;

  gf2m_digit_step #(
    .M     (M),
    .POLY  (POLY),
    .DIGIT (DIGIT)
  ) u_step (
    .i_acc   (r_acc),
    .i_areg  (r_areg),
    .i_bdig  (r_breg[M-1 -: DIGIT]),
    .o_acc_c (w_acc_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath controls; DONE with out_ready doubles as an accept slot.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_in_ready  = 1'b1;
          w_release   = 1'b1;
          if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand, accumulator and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_areg <= '0;
      r_breg <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_areg <= bus.a;
      r_breg <= bus.b;
      r_acc  <= '0;
      r_cnt  <= CW'(N - 1);
    end else if (w_step) begin
      r_acc  <= w_acc_nxt;
      r_breg <= M'(r_breg << DIGIT);
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // Result register and valid flag; c only changes on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_last) begin
        r_c         <= w_acc_nxt;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;

endmodule

// File: tb/tb_gf2m_mult_serial.sv
// Self-checking bench for gf2m_mult_serial: directed field vectors, backpressure,
// back-to-back, mid-operation reset, random handshake stress on the default
// instance, plus DIGIT=2/4/8 and M=4 instances driven with random vectors.
module tb_gf2m_mult_serial;
  import gf2m_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_p = 1'b1;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  gf2m_mult_serial_if #(.M(8)) bus ();

  gf2m_mult_serial #(
    .M     (8),
    .POLY  (8'h1B),
    .DIGIT (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // LSB-first shift-and-add reference product.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned m, input logic [31:0] poly);
    logic [31:0] r;
    logic [31:0] t;
    logic [31:0] bb;
    r  = '0;
    t  = a;
    bb = b;
    for (int i = 0; i < int'(m); i++) begin
      if (bb[0]) r = r ^ t;
      t  = gf2m_xtime(t, poly, m);
      bb = bb >> 1;
    end
    return r;
  endfunction

  logic [7:0] sb_q[$];

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(exp);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
  endtask

  task automatic collect(input string tag);
    int         lat;
    logic [7:0] e;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(tag, 32'(bus.c), 32'(e));
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ov_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin : main
    int         spur;
    int         busy_left;
    int         guard;
    logic       ir;
    logic       ov;
    logic [7:0] e;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed field vectors
    issue(8'h57, 8'h83, 8'hC1); collect("fips_57x83"); release_out();
    issue(8'h57, 8'h13, 8'hFE); collect("fips_57x13"); release_out();
    issue(8'h53, 8'hCA, 8'h01); collect("inverse");    release_out();
    issue(8'hA5, 8'h01, 8'hA5); collect("identity");   release_out();
    issue(8'h00, 8'hFF, 8'h00); collect("zero_op");    release_out();

    // Backpressure then back-to-back
    issue(8'h57, 8'h83, 8'hC1); collect("bp");
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_c_stable", 32'(bus.c), 32'hC1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h02;
    bus.b         = 8'h87;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(8'h15);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("b2b_ov_drop", 32'(bus.out_valid), 32'd0);
    collect("b2b");
    release_out();

    // Mid-operation reset
    issue(8'h57, 8'h83, 8'hC1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_c", 32'(bus.c), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    spur = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) spur++;
    end
    chk("mrst_no_spurious", 32'(spur), 32'd0);
    issue(8'h57, 8'h13, 8'hFE); collect("post_rst"); release_out();

    // Random handshake stress
    busy_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (($urandom % 3) != 0);
      bus.out_ready = 1'($urandom);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      #1;
      if (busy_left > 0) begin
        chk("stress_busy", 32'({bus.in_ready, bus.out_valid}), 32'd0);
        busy_left--;
      end
      ir = bus.in_ready;
      ov = bus.out_valid;
      if (ov && bus.out_ready) begin
        chk("stress_sb", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("stress_c", 32'(bus.c), 32'(e));
        end
      end
      if (ir && bus.in_valid) begin
        sb_q.push_back(8'(ref_mul(32'(bus.a), 32'(bus.b), 8, 32'h1B)));
        busy_left = 8;
      end
      @(posedge clk);
    end

    // Drain
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
      if (bus.out_valid) begin
        e = sb_q.pop_front();
        chk("drain_c", 32'(bus.c), 32'(e));
      end
      @(posedge clk);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Wait for the parametrised instances
    guard = 0;
    while (n_done < 4 && guard < 80000) begin
      @(posedge clk);
      guard++;
    end
    chk("param_blocks_done", 32'(n_done), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : par_reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_p = 1'b0;
  end

  // DIGIT = 2, 4, 8 at M = 8, and M = 4 with P = x^4+x+1
  for (genvar gi = 0; gi < 4; gi++) begin : g_par
    localparam int unsigned  PM = (gi == 3) ? 4 : 8;
    localparam int unsigned  PD = (gi == 3) ? 1 : (2 << gi);
    localparam logic [PM-1:0] PP = (gi == 3) ? PM'(4'h3) : PM'(8'h1B);
    localparam int unsigned  PN = PM / PD;
    localparam int           NV = 2000;

    gf2m_mult_serial_if #(.M(PM)) pbus ();

    gf2m_mult_serial #(
      .M     (PM),
      .POLY  (PP),
      .DIGIT (PD)
    ) u_dut (
      .clk (clk),
      .rst (rst_p),
      .bus (pbus)
    );

    initial begin : drv
      logic [PM-1:0] q_exp[$];
      int            q_cyc[$];
      int            cyc;
      int            issued;
      int            guard;
      int            e0;
      logic [PM-1:0] e;
      logic [PM-1:0] da;
      logic [PM-1:0] db;
      logic [PM-1:0] de;

      if (PM == 4) begin
        da = PM'(4'h9); db = PM'(4'h7); de = PM'(4'hA);
      end else begin
        da = PM'(8'h57); db = PM'(8'h83); de = PM'(8'hC1);
      end
      pbus.in_valid  = 1'b0;
      pbus.out_ready = 1'b1;
      pbus.a         = '0;
      pbus.b         = '0;
      cyc    = 0;
      issued = 0;
      guard  = 0;
      @(negedge rst_p);
      while ((issued < NV || q_exp.size() != 0) && guard < 30000) begin
        @(negedge clk);
        guard++;
        if (issued == 0) begin
          pbus.a = da;
          pbus.b = db;
        end else begin
          pbus.a = PM'($urandom);
          pbus.b = PM'($urandom);
        end
        pbus.in_valid = (issued < NV);
        #1;
        if (pbus.out_valid) begin
          chk($sformatf("par%0d_sb", gi), 32'(q_exp.size() != 0), 32'd1);
          if (q_exp.size() != 0) begin
            e  = q_exp.pop_front();
            e0 = q_cyc.pop_front();
            chk($sformatf("par%0d_c", gi), 32'(pbus.c), 32'(e));
            chk($sformatf("par%0d_lat", gi), 32'(cyc - e0), 32'(PN));
          end
        end
        if (pbus.in_ready && pbus.in_valid) begin
          q_exp.push_back((issued == 0) ? de
                          : PM'(ref_mul(32'(pbus.a), 32'(pbus.b), PM, 32'(PP))));
          q_cyc.push_back(cyc + 1);
          issued++;
        end
        @(posedge clk);
        cyc++;
      end
      chk($sformatf("par%0d_issued", gi), 32'(issued), 32'(NV));
      chk($sformatf("par%0d_drained", gi), 32'(q_exp.size()), 32'd0);
      n_done++;
    end
  end

endmodule
